// File: rtl/fixed_point_subtractor_pkg.sv
// Shared constants for the sign-magnitude fixed-point subtractor.
//   DefaultN / DefaultQ : default word width and fractional bit count
//   SignBit             : index of the sign bit for the default width
//   SatMag              : saturated magnitude (all ones) for the default width
package fixed_point_subtractor_pkg;

    localparam int unsigned DefaultN = 32;
    localparam int unsigned DefaultQ = 15;
    localparam int unsigned SignBit  = DefaultN - 1;

    localparam logic [DefaultN-2:0] SatMag = '1;

endpackage

// File: rtl/fixed_point_subtractor_if.sv
// Operand/result handshake bundle for fixed_point_subtractor.
//   in_valid/in_ready/a/b        : operand transfer (upstream -> block)
//   out_valid/out_ready/c/ovf    : result transfer (block -> downstream)
// Modports:
//   master : the environment side (drives operands, accepts results)
//   slave  : the subtractor side
interface fixed_point_subtractor_if
    import fixed_point_subtractor_pkg::*;
#(
    parameter int unsigned N = DefaultN
) ();

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] c;
    logic         ovf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, c, ovf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, c, ovf
    );

endinterface

// File: rtl/fixed_point_sm_core.sv
// Combinational sign-magnitude arithmetic core.
//   cmp_a, cmp_b       : raw magnitudes to compare (stage-1 side)
//   a_ge_b             : cmp_a >= cmp_b
//   sign_a, sign_b     : effective signs (sign_b already inverted for subtraction)
//   mag_a, mag_b       : registered magnitudes (stage-2 side)
//   larger_a           : registered compare result, mag_a >= mag_b
//   res_sign, res_mag  : sign-magnitude result, never -0
//   res_ovf            : magnitude sum saturated
module fixed_point_sm_core
    import fixed_point_subtractor_pkg::*;
#(
    parameter int unsigned N = DefaultN
) (
    input  logic [N-2:0] cmp_a,
    input  logic [N-2:0] cmp_b,
    output logic         a_ge_b,
    input  logic         sign_a,
    input  logic         sign_b,
    input  logic [N-2:0] mag_a,
    input  logic [N-2:0] mag_b,
    input  logic         larger_a,
    output logic         res_sign,
    output logic [N-2:0] res_mag,
    output logic         res_ovf
);

    localparam logic [N-2:0] MagSat = '1;

    logic [N-1:0] sum;
    logic [N-2:0] diff;

    always_comb begin
        a_ge_b = (cmp_a >= cmp_b);
    end

    always_comb begin
        sum  = {1'b0, mag_a} + {1'b0, mag_b};
        diff = larger_a ? (mag_a - mag_b) : (mag_b - mag_a);

        res_sign = sign_a;
        res_mag  = '0;
        res_ovf  = 1'b0;

        if (sign_a == sign_b) begin
            // Carry out of the magnitude field means the result cannot be represented.
            if (sum[N-1]) begin
                res_mag = MagSat;
                res_ovf = 1'b1;
            end else begin
                res_mag = sum[N-2:0];
            end
        end else begin
            res_mag  = diff;
            res_sign = larger_a ? sign_a : sign_b;
        end

        // Any zero magnitude is reported as +0, which also absorbs -0 inputs.
        if (res_mag == '0) begin
            res_sign = 1'b0;
        end
    end

endmodule

// File: rtl/fixed_point_subtractor.sv
// Two-stage pipelined sign-magnitude subtractor, c = a - b.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : operand/result handshake (slave side)
// Stage 1 holds the sign-adjusted operands and their magnitude compare; stage 2 holds c/ovf.
// Q is informational only and does not affect the datapath.
module fixed_point_subtractor
    import fixed_point_subtractor_pkg::*;
#(
    parameter int unsigned Q = DefaultQ,
    parameter int unsigned N = DefaultN
) (
    input  logic                     clk,
    input  logic                     rst_n,
    fixed_point_subtractor_if.slave  bus
);

    if (Q > N - 1) begin : g_q_check
        $error("fixed_point_subtractor: Q larger than magnitude width");
    end

    logic         s1_valid;
    logic         s1_sign_a;
    logic         s1_sign_b;
    logic [N-2:0] s1_mag_a;
    logic [N-2:0] s1_mag_b;
    logic         s1_a_ge_b;

    logic         out_valid_q;
    logic [N-1:0] c_q;
    logic         ovf_q;

    logic         cmp_ge;
    logic         res_sign;
    logic [N-2:0] res_mag;
    logic         res_ovf;

    logic         s2_adv;
    logic         s1_adv;
    logic         in_fire;

    always_comb begin
        s2_adv  = !out_valid_q || bus.out_ready;
        s1_adv  = !s1_valid || s2_adv;
        in_fire = bus.in_valid && s1_adv;
    end

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = out_valid_q;
    assign bus.c         = c_q;
    assign bus.ovf       = ovf_q;

    fixed_point_sm_core #(
        .N (N)
    ) u_core (
        .cmp_a    (bus.a[N-2:0]),
        .cmp_b    (bus.b[N-2:0]),
        .a_ge_b   (cmp_ge),
        .sign_a   (s1_sign_a),
        .sign_b   (s1_sign_b),
        .mag_a    (s1_mag_a),
        .mag_b    (s1_mag_b),
        .larger_a (s1_a_ge_b),
        .res_sign (res_sign),
        .res_mag  (res_mag),
        .res_ovf  (res_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_sign_a   <= 1'b0;
            s1_sign_b   <= 1'b0;
            s1_mag_a    <= '0;
            s1_mag_b    <= '0;
            s1_a_ge_b   <= 1'b0;
            out_valid_q <= 1'b0;
            c_q         <= '0;
            ovf_q       <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= bus.in_valid;
            end
            if (in_fire) begin
                s1_sign_a <= bus.a[N-1];
                // Subtraction is addition with the subtrahend's sign flipped.
                s1_sign_b <= ~bus.b[N-1];
                s1_mag_a  <= bus.a[N-2:0];
                s1_mag_b  <= bus.b[N-2:0];
                s1_a_ge_b <= cmp_ge;
            end
            if (s2_adv) begin
                out_valid_q <= s1_valid;
            end
            if (s2_adv && s1_valid) begin
                c_q   <= {res_sign, res_mag};
                ovf_q <= res_ovf;
            end
        end
    end

endmodule

// File: tb/tb_fixed_point_subtractor.sv
// Self-checking bench for fixed_point_subtractor (N=32, Q=15).
// Inputs change on the falling edge; the scoreboard monitor samples 1 ns later and the
// scenario tasks sample 2 ns later, so all observations are away from the rising edge.
module tb_fixed_point_subtractor;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [32:0] sb[$];

    fixed_point_subtractor_if #(.N(32)) bus ();

    fixed_point_subtractor #(
        .Q (15),
        .N (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: signed integer difference, clamped to the representable magnitude.
    function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y);
        longint      vx;
        longint      vy;
        longint      d;
        longint      lim;
        logic        s;
        logic [30:0] m;
        logic        o;
        vx = {33'd0, x[30:0]};
        vy = {33'd0, y[30:0]};
        if (x[31]) vx = -vx;
        if (y[31]) vy = -vy;
        d   = vx - vy;
        lim = 64'sd2147483647;
        o   = 1'b0;
        if (d > lim) begin
            o = 1'b1; s = 1'b0; m = '1;
        end else if (d < -lim) begin
            o = 1'b1; s = 1'b1; m = '1;
        end else begin
            s = (d < 0);
            m = s ? 31'(-d) : 31'(d);
        end
        return {o, s, m};
    endfunction

    // Scoreboard: push on input transfer, pop and compare on output transfer.
    always @(negedge clk) begin
        logic [32:0] exp;
        #1;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_output got c=%h ovf=%b, required no output",
                             bus.c, bus.ovf);
                end else begin
                    exp = sb.pop_front();
                    if ({bus.ovf, bus.c} !== exp) begin
                        errors++;
                        $display("FAIL sb_result got c=%h ovf=%b, required c=%h ovf=%b",
                                 bus.c, bus.ovf, exp[31:0], exp[32]);
                    end
                end
                checks++;
                if (bus.c === 32'h8000_0000) begin
                    errors++;
                    $display("FAIL sb_neg_zero got c=%h, required never 80000000", bus.c);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(model(bus.a, bus.b));
            end
        end
    end

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < 50) begin
            @(negedge clk);
            #2;
            n++;
        end
        checks++;
        if (sb.size() != 0 || bus.out_valid) begin
            errors++;
            $display("FAIL %s_drain got pending=%0d out_valid=%b, required 0 and 0",
                     name, sb.size(), bus.out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (2) @(negedge clk);
        #2;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b, required 0", bus.out_valid);
        end
        checks++;
        if (bus.c !== 32'h0) begin
            errors++; $display("FAIL reset_c got %h, required 00000000", bus.c);
        end
        checks++;
        if (bus.ovf !== 1'b0) begin
            errors++; $display("FAIL reset_ovf got %b, required 0", bus.ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b, required 1", bus.in_ready);
        end
    endtask

    task automatic test_latency();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = 32'h0000_C000;
        bus.b        = 32'h0000_4000;
        #2;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL lat_in_ready got %b, required 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL lat_early got out_valid=%b, required 0", bus.out_valid);
        end
        @(negedge clk);
        #2;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.c !== 32'h0000_8000 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL lat_result got v=%b c=%h ovf=%b, required v=1 c=00008000 ovf=0",
                     bus.out_valid, bus.c, bus.ovf);
        end
        drain("lat");
    endtask

    task automatic test_directed();
        logic [31:0] ta[13];
        logic [31:0] tb_[13];
        logic [32:0] te[13];
        ta = '{32'h0000_4000, 32'h0001_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000,
               32'h0000_0000, 32'h8000_1234, 32'hFFFF_FFFF, 32'h0000_0003, 32'h8000_0005,
               32'h7FFF_FFFF, 32'h4000_0000, 32'h3FFF_FFFF};
        tb_ = '{32'h0000_C000, 32'h0001_0000, 32'h8000_0001, 32'h0000_0000, 32'h8000_0000,
                32'h8000_0005, 32'h0000_0234, 32'h7FFF_FFFF, 32'h0000_0005, 32'h8000_0003,
                32'h7FFF_FFFF, 32'hC000_0000, 32'hC000_0000};
        te = '{{1'b0, 32'h8000_8000}, {1'b0, 32'h0000_0000}, {1'b1, 32'h7FFF_FFFF},
               {1'b0, 32'h0000_0000}, {1'b0, 32'h0000_0000}, {1'b0, 32'h0000_0005},
               {1'b0, 32'h8000_1468}, {1'b1, 32'hFFFF_FFFF}, {1'b0, 32'h8000_0002},
               {1'b0, 32'h8000_0002}, {1'b0, 32'h0000_0000}, {1'b1, 32'h7FFF_FFFF},
               {1'b0, 32'h7FFF_FFFF}};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.a        = ta[i];
            bus.b        = tb_[i];
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.a        = 32'hDEAD_BEEF;
            bus.b        = 32'h1234_5678;
            @(negedge clk);
            #2;
            checks++;
            if (bus.out_valid !== 1'b1 || {bus.ovf, bus.c} !== te[i]) begin
                errors++;
                $display("FAIL dir_%0d got v=%b c=%h ovf=%b, required v=1 c=%h ovf=%b",
                         i, bus.out_valid, bus.c, bus.ovf, te[i][31:0], te[i][32]);
            end
        end
        drain("dir");
    endtask

    task automatic test_backpressure();
        logic [31:0] pa[3];
        logic [31:0] pb[3];
        logic [32:0] first;
        logic [31:0] held_c;
        logic        held_ovf;
        logic        have_held;
        int          idx;
        int          accepted;
        int          n;
        pa = '{32'h0005_0000, 32'h8002_0000, 32'h0000_1000};
        pb = '{32'h0001_8000, 32'h0003_0000, 32'h8000_2000};
        first     = model(pa[0], pb[0]);
        idx       = 0;
        accepted  = 0;
        have_held = 1'b0;
        held_c    = '0;
        held_ovf  = 1'b0;
        bus.out_ready = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.a        = pa[idx];
            bus.b        = pb[idx];
            #2;
            if (bus.in_ready) begin
                accepted++;
                if (idx < 2) idx++;
            end
            if (bus.out_valid) begin
                if (!have_held) begin
                    have_held = 1'b1;
                    held_c    = bus.c;
                    held_ovf  = bus.ovf;
                end else begin
                    checks++;
                    if (bus.c !== held_c || bus.ovf !== held_ovf) begin
                        errors++;
                        $display("FAIL bp_stable got c=%h ovf=%b, required c=%h ovf=%b",
                                 bus.c, bus.ovf, held_c, held_ovf);
                    end
                end
            end
        end
        checks++;
        if (accepted != 2) begin
            errors++; $display("FAIL bp_accepted got %0d, required 2", accepted);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_in_ready got %b, required 0", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b1 || {bus.ovf, bus.c} !== first) begin
            errors++;
            $display("FAIL bp_head got v=%b c=%h ovf=%b, required v=1 c=%h ovf=%b",
                     bus.out_valid, bus.c, bus.ovf, first[31:0], first[32]);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        n = 0;
        #2;
        while (!bus.in_ready && n < 10) begin
            @(negedge clk);
            #2;
            n++;
        end
        checks++;
        if (!bus.in_ready) begin
            errors++; $display("FAIL bp_resume got in_ready=%b, required 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        drain("bp");
    endtask

    task automatic test_back_to_back();
        int outs;
        int not_ready;
        outs      = 0;
        not_ready = 0;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.a        = $urandom;
            bus.b        = $urandom;
            if ($urandom_range(3) == 0) bus.a[30:0] = '1;
            if ($urandom_range(3) == 0) bus.b[30:0] = '1;
            if ($urandom_range(7) == 0) bus.b[30:0] = bus.a[30:0];
            #2;
            if (!bus.in_ready) not_ready++;
            if (bus.out_valid) outs++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2;
        if (bus.out_valid) outs++;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            #2;
            if (bus.out_valid) outs++;
        end
        checks++;
        if (not_ready != 0) begin
            errors++; $display("FAIL b2b_in_ready got %0d stalls, required 0", not_ready);
        end
        checks++;
        if (outs != 16) begin
            errors++; $display("FAIL b2b_count got %0d results, required 16", outs);
        end
        drain("b2b");
    endtask

    task automatic test_reset_flush();
        int stale;
        stale = 0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = 32'h0003_0000;
        bus.b        = 32'h0001_0000;
        @(negedge clk);
        bus.a        = 32'h8004_0000;
        bus.b        = 32'h0002_0000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.c !== 32'h0 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear got v=%b c=%h ovf=%b, required v=0 c=00000000 ovf=0",
                     bus.out_valid, bus.c, bus.ovf);
        end
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            #2;
            if (bus.out_valid) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++; $display("FAIL flush_stale got %0d stale results, required 0", stale);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_latency();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_reset_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fixed_point_subtractor.md
FIXED_POINT_SUBTRACTOR -- requirements
Module: fixed_point_subtractor

Interface
REQ-001 SHALL have parameter Q, default 15, number of fractional magnitude bits (informational; does not change datapath behaviour).
REQ-002 SHALL have parameter N, default 32, total word width: bit N-1 sign (1 = negative), bits N-2:0 magnitude.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand pair a/b valid.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port a  input  N  minuend, sign-magnitude.
REQ-008 SHALL have port b  input  N  subtrahend, sign-magnitude.
REQ-009 SHALL have port out_valid  output  1  c/ovf hold a valid result.
REQ-010 SHALL have port out_ready  input  1  downstream accepts result.
REQ-011 SHALL have port c  output  N  difference a - b, sign-magnitude.
REQ-012 SHALL have port ovf  output  1  magnitude saturated for this result.

Function
REQ-013 SHALL compute c = a - b by inverting sign of b, then sign-magnitude addition.
REQ-014 Effective signs equal: SHALL output magnitude = |a| + |b| over N-1 bits, sign = sign of a.
REQ-015 Carry out of bit N-2 on magnitude sum: SHALL saturate magnitude to all ones (sign kept), ovf = 1; otherwise ovf = 0.
REQ-016 Effective signs differ: SHALL output larger magnitude minus smaller, sign of the larger-magnitude operand; ovf = 0.
REQ-017 Zero result (including equal magnitudes, opposite effective signs): SHALL output +0 (all bits 0); -0 never produced.
REQ-018 Input -0 SHALL be treated identically to +0.
REQ-019 Two-stage pipeline: stage 1 registers sign-adjusted operands and magnitude compare; stage 2 registers c/ovf; latency 2 cycles from accepted transfer to out_valid with no backpressure.
REQ-020 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-021 Stage 2 advances when !out_valid || out_ready; stage 1 advances when stage 1 empty or stage 2 advances; in_ready SHALL equal the stage-1 advance term (combinational from out_ready allowed).
REQ-022 SHALL sustain one result per cycle when out_ready held high.
REQ-023 While out_valid && !out_ready, c/ovf/out_valid SHALL hold stable; no result lost, duplicated or reordered.
REQ-024 Simultaneous output transfer and input transfer SHALL both complete in the same cycle.
REQ-025 a/b SHALL be ignored when no input transfer occurs.

Reset
REQ-026 rst_n low at a rising edge SHALL clear both stage valid flags; out_valid = 0, c = 0, ovf = 0.
REQ-027 in_ready SHALL be 1 in the first cycle after reset release.
REQ-028 Reset mid-operation SHALL discard all in-flight operands; no stale result ever appears afterwards.

Structure
REQ-029 Shared package SHALL hold default N/Q constants, sign-bit index, and the saturated-magnitude constant.
REQ-030 One sub-module fixed_point_sm_core SHALL implement the combinational magnitude compare/add/subtract/saturate; the top holds pipeline registers and handshake.

Verification (N=32, Q=15)
REQ-031 a=0x0000C000 (1.5), b=0x00004000 (0.5), out_ready=1 -> c=0x00008000, ovf=0, out_valid exactly 2 cycles after accept.
REQ-032 a=0x00004000, b=0x0000C000 -> c=0x80008000 (-1.0); a=b=0x00010000 -> c=0x00000000, never 0x80000000.
REQ-033 a=0x7FFFFFFF, b=0x80000001 -> c=0x7FFFFFFF, ovf=1; a=0x80000000, b=0x00000000 -> c=0x00000000.
REQ-034 out_ready=0 for 4 cycles, in_valid=1 with 3 distinct pairs -> exactly 2 accepted, in_ready=0 thereafter, outputs stable; on out_ready=1 results emerge in order, none lost.
REQ-035 Back-to-back 16 random pairs, out_ready=1 -> one result per cycle, all match reference model.
REQ-036 rst_n low for 1 cycle with 2 results in flight -> out_valid=0, c=0, ovf=0 next cycle, no stale output after release.
